// File: rtl/chol_pkg.sv
// ---------------------------------------------------------------------------
// chol_pkg : shared types and widths for the Cholesky MAC sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package chol_pkg;

  localparam int CHOL_MAC_A_W      = 32;
  localparam int CHOL_MAC_P_W      = 64;
  localparam int CHOL_MAC_LATENCY  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } chol_state_e;

endpackage

`default_nettype wire

// File: rtl/chol_mac.sv
// ---------------------------------------------------------------------------
// chol_mac : pipelined P = C - A*B, signed 32x32 product, 64-bit wrap
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chol_mac
  import chol_pkg::*;
#(
  parameter int LATENCY = CHOL_MAC_LATENCY
) (
  input  logic                    clk,
  input  logic                    sclr,
  input  logic                    ce,
  input  logic [CHOL_MAC_A_W-1:0] a,
  input  logic [CHOL_MAC_A_W-1:0] b,
  input  logic [CHOL_MAC_P_W-1:0] c,
  output logic [CHOL_MAC_P_W-1:0] p
);

  logic [CHOL_MAC_P_W-1:0] a_ext;
  logic [CHOL_MAC_P_W-1:0] b_ext;
  logic [CHOL_MAC_P_W-1:0] stage_d;
  logic [CHOL_MAC_P_W-1:0] stage_q [LATENCY];

  // Sign-extend first so the low 64 bits of the product are the signed result.
  always_comb begin
    a_ext   = {{(CHOL_MAC_P_W-CHOL_MAC_A_W){a[CHOL_MAC_A_W-1]}}, a};
    b_ext   = {{(CHOL_MAC_P_W-CHOL_MAC_A_W){b[CHOL_MAC_A_W-1]}}, b};
    stage_d = c - (a_ext * b_ext);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else if (ce) begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign p = stage_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/chol_mac_unit.sv
// ---------------------------------------------------------------------------
// chol_mac_unit : chol_mac_seq bound to its chol_mac instance
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chol_mac_unit
  import chol_pkg::*;
#(
  parameter int MAC_LATENCY = CHOL_MAC_LATENCY,
  parameter int LEN_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [CHOL_MAC_P_W-1:0] init,
  input  logic [LEN_W-1:0]        len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [CHOL_MAC_A_W-1:0] op_a,
  input  logic [CHOL_MAC_A_W-1:0] op_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CHOL_MAC_P_W-1:0] res_data
);

  logic                    mac_clken;
  logic                    mac_rst;
  logic [CHOL_MAC_A_W-1:0] mac_a;
  logic [CHOL_MAC_A_W-1:0] mac_b;
  logic [CHOL_MAC_P_W-1:0] mac_c;
  logic [CHOL_MAC_P_W-1:0] mac_out;

  chol_mac_seq #(
    .MAC_LATENCY (MAC_LATENCY),
    .LEN_W       (LEN_W)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .init        (init),
    .len         (len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .mac_clken   (mac_clken),
    .mac_rst     (mac_rst),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_c       (mac_c),
    .mac_out     (mac_out)
  );

  chol_mac #(
    .LATENCY (MAC_LATENCY)
  ) u_mac (
    .clk  (clk),
    .sclr (mac_rst),
    .ce   (mac_clken),
    .a    (mac_a),
    .b    (mac_b),
    .c    (mac_c),
    .p    (mac_out)
  );

endmodule

`default_nettype wire

// File: rtl/chol_mac_seq.sv
// ---------------------------------------------------------------------------
// chol_mac_seq : drives one chol_mac to compute init - sum(a_k*b_k)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chol_mac_seq
  import chol_pkg::*;
#(
  parameter int MAC_LATENCY = CHOL_MAC_LATENCY,
  parameter int LEN_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [CHOL_MAC_P_W-1:0] init,
  input  logic [LEN_W-1:0]        len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [CHOL_MAC_A_W-1:0] op_a,
  input  logic [CHOL_MAC_A_W-1:0] op_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CHOL_MAC_P_W-1:0] res_data,
  output logic                    mac_clken,
  output logic                    mac_rst,
  output logic [CHOL_MAC_A_W-1:0] mac_a,
  output logic [CHOL_MAC_A_W-1:0] mac_b,
  output logic [CHOL_MAC_P_W-1:0] mac_c,
  input  logic [CHOL_MAC_P_W-1:0] mac_out
);

  localparam int CNT_W = $clog2(MAC_LATENCY + 1);

  chol_state_e             state_q, state_d;
  logic [CHOL_MAC_P_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CHOL_MAC_A_W-1:0] mac_a_q, mac_a_d;
  logic [CHOL_MAC_A_W-1:0] mac_b_q, mac_b_d;
  logic [CHOL_MAC_P_W-1:0] mac_c_q, mac_c_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
    end else begin
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          acc_d       = init;
          remaining_d = len;
          state_d     = (len != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (op_valid) begin
          mac_a_d = op_a;
          mac_b_d = op_b;
          mac_c_d = acc_q;
          cnt_d   = CNT_W'(MAC_LATENCY);
          state_d = ST_WAIT;
        end
      end
      // cnt counts the MAC's enabled edges; the last one lands mac_out for CAPTURE.
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        acc_d       = mac_out;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q == LEN_W'(1)) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == ST_IDLE);
    op_ready    = (state_q == ST_FETCH);
    mac_clken   = (state_q == ST_WAIT);
    res_valid   = (state_q == ST_DONE);
    res_data    = acc_q;
    mac_rst     = rst;
    mac_a       = mac_a_q;
    mac_b       = mac_b_q;
    mac_c       = mac_c_q;
  end

endmodule

`default_nettype wire

// File: doc/chol_mac_seq.md
# chol_mac_seq

Sequencer that drives one `chol_mac` (P = C − A·B, pipelined, 64-bit) to evaluate a Cholesky inner-product term: result = init − Σ a_k·b_k over `len` operand pairs. It accepts a job (initial value plus term count), pulls operand pairs from a valid/ready stream, feeds each MAC output back as the next C, and presents the final 64-bit value on a valid/ready result port. It sits between the Cholesky row/column scheduler and the MAC instance, hiding the MAC feedback latency from the scheduler.

## Interface
- `MAC_LATENCY`, 4: enabled rising edges from the edge at which the MAC samples A/B/C to the edge after which P holds the result; legal ≥ 1.
- `LEN_W`, 8: width of the term-count field.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start_valid` in 1: job request.
- `start_ready` out 1: job accept; high only in IDLE.
- `init` in 64: initial accumulator value (signed), sampled on start handshake.
- `len` in LEN_W: number of operand pairs, sampled on start handshake; 0 is legal.
- `op_valid` in 1, `op_ready` out 1: operand-pair handshake.
- `op_a`, `op_b` in 32 each: signed operands.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out 64: final accumulator.
- `mac_clken` out 1, `mac_rst` out 1: to MAC CE / SCLR.
- `mac_a`, `mac_b` out 32, `mac_c` out 64: registered MAC operands.
- `mac_out` in 64: MAC P.

## Operation
- States: IDLE, FETCH, WAIT, CAPTURE, DONE.
- IDLE: `start_ready`=1. On `start_valid`: acc←init, remaining←len; go FETCH if len≠0, else DONE.
- FETCH: `op_ready`=1. On `op_valid`: mac_a←op_a, mac_b←op_b, mac_c←acc, cnt←MAC_LATENCY; go WAIT. Without `op_valid`, stay; no timeout.
- WAIT: `mac_clken`=1; cnt decrements each cycle; after exactly MAC_LATENCY cycles go CAPTURE.
- CAPTURE: acc←mac_out, remaining←remaining−1; go DONE if remaining was 1, else FETCH. `mac_clken`=0.
- DONE: `res_valid`=1, `res_data`=acc (stable while stalled). On `res_ready`, go IDLE.
- `mac_clken` is high only in WAIT; MAC state is frozen otherwise.
- `mac_rst` = `rst` (combinational pass-through); no other MAC flush.
- Arithmetic is done entirely in the MAC: signed 32×32→64 product, 64-bit subtract wrapping mod 2^64. The controller does no width extension or saturation.
- Reset values: state IDLE; `start_ready`=1 (combinational from IDLE); `op_ready`, `res_valid`, `mac_clken`=0; `mac_a`, `mac_b`, `mac_c`, acc, `res_data`=0; remaining, cnt=0.
- Reset in any state, including mid-WAIT, aborts the job: IDLE next cycle, no result emitted, MAC cleared via `mac_rst`.
- The result handshake never overlaps the acceptance of a new job. A start request arriving during DONE waits until IDLE.

## Timing
- Per term: 1 FETCH cycle (if `op_valid` is already high) + MAC_LATENCY WAIT cycles + 1 CAPTURE cycle = MAC_LATENCY+2.
- With the start handshake in cycle t and operands always valid, `res_valid` first rises in cycle t+1+len·(MAC_LATENCY+2). For len=0, it rises in t+1.
- `op_ready` deasserts the cycle after an operand is accepted. At most one operand is accepted per term.
- Throughput: one job in flight; the next start is accepted no earlier than the cycle after the result handshake.

## Structure
- Shared package `chol_pkg`: state enum type, `CHOL_MAC_A_W`=32, `CHOL_MAC_P_W`=64, default `MAC_LATENCY`.
- One natural sub-module: the `chol_mac` instance itself, placed in a thin wrapper `chol_mac_unit` that instantiates `chol_mac_seq` and `chol_mac` together. The sequencer stays MAC-agnostic through its `mac_*` ports.

## Test plan
- MAC_LATENCY=4, init=100, len=3, pairs (2,3),(4,5),(1,1) with `op_valid` held high → `res_data`=73, `res_valid` in cycle t+19.
- len=0, init=−5 → `res_data`=−5 at t+1; `op_ready` and `mac_clken` never assert.
- Signed values: init=0, pair (−7, 6) → `res_data`=42. Pair (0x7FFFFFFF, 0x7FFFFFFF) with init=0 → 0xC000_0000_FFFF_FFFF (two's complement of 0x3FFF_FFFF_0000_0001).
- `op_valid` gaps of 3 cycles between pairs, and `res_ready` held low for 5 cycles in DONE → correct result; `res_data` stable while stalled; exactly len operand handshakes occur.
- `rst` pulsed in the 2nd WAIT cycle of term 2 → outputs return to reset values the next cycle, no `res_valid`; a following job (init=10, pair (1,2)) returns 8.
- `start_valid` asserted continuously across back-to-back jobs → a second start is accepted only in IDLE, after the prior `res_valid`&`res_ready`.
